peak_capture_ctrl: RTL and testbench
====================================

// Module: peak_capture_ctrl
// PURPOSE
//  Sequences the transfer of per-channel peak/index results into the peak and index DPRAMs.
//  Waits until every channel has flagged end-of-frame, then streams NUM_PEAKS*CHANNELS entries
//  (one per cycle) to the DPRAM write port. Next it raises peaks_ready and holds it until host ack.
//  Sits between the peak_detect_fast_shell array and the DPRAM write ports; runs in process_clks[0].
// PARAMETERS
//  CHANNELS     8   number of detector channels
//  NUM_PEAKS    16  peaks per channel (power of 2 not required)
//  VALUE_WIDTH  16  peak value width
//  INDEX_WIDTH  11  peak index width
//  ADDR_WIDTH   7   DPRAM address width; must satisfy 2**ADDR_WIDTH >= NUM_PEAKS*CHANNELS
// PORTS
//  clk          in   1                          stream clock (process_clks[0])
//  aresetn      in   1                          async active-low reset
//  ch_done      in   CHANNELS                   1-cycle end-of-frame pulse per channel, already in clk domain
//  peaks        in   CHANNELS*NUM_PEAKS*VALUE_WIDTH   flat peak bus, entry e at [e*VALUE_WIDTH +: VALUE_WIDTH]
//  indices      in   CHANNELS*NUM_PEAKS*INDEX_WIDTH   flat index bus, same ordering
//  host_ack     in   1                          software consumed frame; sampled only in PUBLISH
//  clr_overrun  in   1                          clears sticky overrun
//  wr_en        out  1                          DPRAM write enable
//  wr_addr      out  ADDR_WIDTH                 DPRAM write address
//  wr_peak      out  VALUE_WIDTH                data to peak DPRAM
//  wr_index     out  INDEX_WIDTH                data to index DPRAM
//  busy         out  1                          high in WRITE and PUBLISH
//  peaks_ready  out  1                          level; frame in DPRAM valid, until host_ack
//  overrun      out  1                          sticky: a channel finished a frame that was dropped
//  frame_cnt    out  16                         frames published, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: state=COLLECT; done_lat=0; cnt=0; all outputs 0.
//  done_lat[c]: set by ch_done[c] in any state. Cleared on the COLLECT->WRITE transition.
//   If ch_done[c] arrives in that same cycle, the set wins, so the pulse counts for the next frame.
//  Overrun: ch_done[c] while done_lat[c]==1 and not the clearing cycle -> overrun<=1.
//   clr_overrun clears it; a simultaneous set wins.
//  FSM:
//   COLLECT: if &done_lat -> WRITE, cnt<=0.
//   WRITE: cnt increments every cycle; when cnt==N-1 (N=NUM_PEAKS*CHANNELS) -> DRAIN.
//   DRAIN: one cycle for the final pipelined write to land -> PUBLISH; peaks_ready<=1.
//   PUBLISH: peaks_ready held 1; host_ack==1 -> COLLECT, peaks_ready<=0, frame_cnt<=frame_cnt+1.
//  Write pipeline (1 stage): in WRITE each cycle registers wr_en<=1, wr_addr<=cnt,
//   wr_peak<=peaks[cnt], wr_index<=indices[cnt]; otherwise wr_en<=0, data holds.
//  Latency: &done_lat seen at edge T -> first wr_en high after edge T+2 (addr 0).
//   wr_en stays high exactly N consecutive cycles (addrs 0..N-1 ascending).
//   peaks_ready rises the cycle after the final wr_en cycle.
//  Ordering: addr = ch*NUM_PEAKS + k, identical to the flat bus entry index.
//  peaks/indices must be stable from WRITE entry until DRAIN; the controller does not snapshot them.
//  Frames completing during WRITE/DRAIN/PUBLISH only set done_lat (or overrun).
//   They are never written mid-publish. A complete done_lat set in PUBLISH starts WRITE right after ack.
//  host_ack outside PUBLISH is ignored. cnt never exceeds N-1. Unused addrs >=N are never written.
//  Async reset mid-WRITE aborts immediately: wr_en=0 and no peaks_ready; the partial frame is not published.
// STRUCTURE
//  Constants CHANNELS, NUM_PEAKS, VALUE_WIDTH, INDEX_WIDTH and FSM state encodings go in constants.vh.
//  The mux+register stage is a natural sub-module: peak_entry_mux (cnt in, registered peak/index out).
//  Top level instantiates it once alongside the FSM, done latches and counters.
// TESTING
//  1 Pulse ch_done 0..7 on separate cycles -> wr_en 128 cycles, addrs 0..127; peaks_ready 1 cycle after; frame_cnt 0->1 on ack.
//  2 peaks entry e = e+0x100 -> DPRAM model holds 0x100..0x17F at addrs 0..127; indices likewise.
//  3 ch_done[3] twice before others complete -> overrun=1; frame still completes; clr_overrun -> 0.
//  4 All ch_done during PUBLISH, ack 10 cycles later -> no writes before ack; WRITE starts 1 cycle after ack.
//  5 ch_done[0] on the COLLECT->WRITE clearing cycle -> done_lat[0]=1 afterwards, overrun stays 0.
//  6 aresetn low at cnt=40 -> wr_en=0 immediately; after release, peaks_ready=0, frame_cnt unchanged, COLLECT.

Source files
------------

// File: rtl/peak_capture_ctrl_pkg.sv
// peak_capture_ctrl_pkg
//   Shared constants and types for the peak capture controller.
//   Holds the default geometry of the detector array (channel count,
//   peaks per channel, value/index/address widths), the controller
//   state encoding and a helper that sizes the DPRAM frame.
package peak_capture_ctrl_pkg;

    localparam int DEF_CHANNELS        = 8;
    localparam int DEF_NUM_PEAKS       = 16;
    localparam int DEF_VALUE_WIDTH     = 16;
    localparam int DEF_INDEX_WIDTH     = 11;
    localparam int DEF_ADDR_WIDTH      = 7;
    localparam int FRAME_CNT_WIDTH     = 16;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_WRITE   = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_PUBLISH = 2'd3
    } state_t;

    // Number of DPRAM entries one frame occupies.
    function automatic int entry_count(input int channels, input int num_peaks);
        return channels * num_peaks;
    endfunction

endpackage

// File: rtl/peak_capture_ctrl_peak_entry_mux.sv
// peak_capture_ctrl_peak_entry_mux
//   Selects flat-bus entry 'cnt' from the peak and index buses and registers
//   it, together with the write enable and address, for the DPRAM write port.
//   Ports:
//     clk, aresetn    stream clock, async active-low reset
//     load            1 = register a write of entry 'cnt' this cycle
//     cnt             entry number (ch*NUM_PEAKS + k)
//     peaks, indices  flat buses, entry e at [e*W +: W]
//     wr_en/wr_addr   registered DPRAM write enable and address
//     wr_peak/index   registered DPRAM write data (held when not loading)
module peak_capture_ctrl_peak_entry_mux
    import peak_capture_ctrl_pkg::*;
#(
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int NUM_PEAKS   = DEF_NUM_PEAKS,
    parameter int VALUE_WIDTH = DEF_VALUE_WIDTH,
    parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
    input  logic                                      clk,
    input  logic                                      aresetn,
    input  logic                                      load,
    input  logic [ADDR_WIDTH-1:0]                     cnt,
    input  logic [CHANNELS*NUM_PEAKS*VALUE_WIDTH-1:0] peaks,
    input  logic [CHANNELS*NUM_PEAKS*INDEX_WIDTH-1:0] indices,
    output logic                                      wr_en,
    output logic [ADDR_WIDTH-1:0]                     wr_addr,
    output logic [VALUE_WIDTH-1:0]                    wr_peak,
    output logic [INDEX_WIDTH-1:0]                    wr_index
);

    localparam int N     = entry_count(CHANNELS, NUM_PEAKS);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [VALUE_WIDTH-1:0] peak_tab  [DEPTH];
    logic [INDEX_WIDTH-1:0] index_tab [DEPTH];

    // Reshape the flat buses into tables addressable by cnt. Slots beyond
    // the frame are tied to zero so the table covers the full address range;
    // the controller never selects them.
    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        if (e < N) begin : g_used
            assign peak_tab[e]  = peaks[e*VALUE_WIDTH +: VALUE_WIDTH];
            assign index_tab[e] = indices[e*INDEX_WIDTH +: INDEX_WIDTH];
        end else begin : g_unused
            assign peak_tab[e]  = '0;
            assign index_tab[e] = '0;
        end
    end

    // Single pipeline stage toward the DPRAM. Data holds between frames so
    // the write port only toggles while a frame is being streamed.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_peak  <= '0;
            wr_index <= '0;
        end else if (load) begin
            wr_en    <= 1'b1;
            wr_addr  <= cnt;
            wr_peak  <= peak_tab[cnt];
            wr_index <= index_tab[cnt];
        end else begin
            wr_en    <= 1'b0;
        end
    end

endmodule

// File: rtl/peak_capture_ctrl.sv
// peak_capture_ctrl
//   Collects end-of-frame flags from every detector channel, then streams
//   all CHANNELS*NUM_PEAKS peak/index entries into the DPRAMs one per cycle,
//   raises peaks_ready and holds it until the host acknowledges.
//   Ports:
//     clk, aresetn      stream clock, async active-low reset
//     ch_done           per-channel 1-cycle end-of-frame pulse
//     peaks, indices    flat result buses (must stay stable WRITE..DRAIN)
//     host_ack          host consumed the frame (only honoured in PUBLISH)
//     clr_overrun       clears the sticky overrun flag
//     wr_en, wr_addr,
//     wr_peak, wr_index DPRAM write port
//     busy              frame transfer or publication in progress
//     peaks_ready       frame in DPRAM is valid
//     overrun           sticky: a channel finished a frame that was dropped
//     frame_cnt         frames published (wrapping)
//   2**ADDR_WIDTH must be at least CHANNELS*NUM_PEAKS.
module peak_capture_ctrl
    import peak_capture_ctrl_pkg::*;
#(
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int NUM_PEAKS   = DEF_NUM_PEAKS,
    parameter int VALUE_WIDTH = DEF_VALUE_WIDTH,
    parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
    input  logic                                      clk,
    input  logic                                      aresetn,
    input  logic [CHANNELS-1:0]                       ch_done,
    input  logic [CHANNELS*NUM_PEAKS*VALUE_WIDTH-1:0] peaks,
    input  logic [CHANNELS*NUM_PEAKS*INDEX_WIDTH-1:0] indices,
    input  logic                                      host_ack,
    input  logic                                      clr_overrun,
    output logic                                      wr_en,
    output logic [ADDR_WIDTH-1:0]                     wr_addr,
    output logic [VALUE_WIDTH-1:0]                    wr_peak,
    output logic [INDEX_WIDTH-1:0]                    wr_index,
    output logic                                      busy,
    output logic                                      peaks_ready,
    output logic                                      overrun,
    output logic [FRAME_CNT_WIDTH-1:0]                frame_cnt
);

    localparam int N = entry_count(CHANNELS, NUM_PEAKS);
    localparam logic [ADDR_WIDTH-1:0] LAST_ENTRY = ADDR_WIDTH'(N - 1);

    state_t                state;
    state_t                next_state;
    logic [CHANNELS-1:0]   done_lat;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  all_done;
    logic                  start_write;
    logic                  write_active;

    assign all_done = &done_lat;

    // State register.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ST_COLLECT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. DRAIN exists only to let the last registered write
    // land before the frame is declared valid.
    always_comb begin
        next_state = state;
        case (state)
            ST_COLLECT: if (all_done)          next_state = ST_WRITE;
            ST_WRITE:   if (cnt == LAST_ENTRY) next_state = ST_DRAIN;
            ST_DRAIN:                          next_state = ST_PUBLISH;
            ST_PUBLISH: if (host_ack)          next_state = ST_COLLECT;
            default:                           next_state = ST_COLLECT;
        endcase
    end

    // State-decoded outputs and internal strobes.
    always_comb begin
        busy         = (state != ST_COLLECT);
        peaks_ready  = (state == ST_PUBLISH);
        write_active = (state == ST_WRITE);
        start_write  = (state == ST_COLLECT) && all_done;
    end

    // Done latches. The clear on entering WRITE is applied before OR-ing in
    // new pulses, so a pulse landing on the clearing cycle belongs to the
    // next frame rather than being lost.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            done_lat <= '0;
        end else begin
            done_lat <= (start_write ? '0 : done_lat) | ch_done;
        end
    end

    // Sticky overrun: a second end-of-frame from a channel whose previous
    // frame has not yet been consumed. The clearing cycle is exempt because
    // its latched flags are being consumed right then. Set beats clear.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            overrun <= 1'b0;
        end else if (!start_write && |(ch_done & done_lat)) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

    // Entry counter; parks at the last entry so it never runs past the frame.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cnt <= '0;
        end else if (start_write) begin
            cnt <= '0;
        end else if (write_active && cnt != LAST_ENTRY) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Published-frame counter, bumped when the host releases the frame.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            frame_cnt <= '0;
        end else if (state == ST_PUBLISH && host_ack) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    peak_capture_ctrl_peak_entry_mux #(
        .CHANNELS    (CHANNELS),
        .NUM_PEAKS   (NUM_PEAKS),
        .VALUE_WIDTH (VALUE_WIDTH),
        .INDEX_WIDTH (INDEX_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_entry_mux (
        .clk      (clk),
        .aresetn  (aresetn),
        .load     (write_active),
        .cnt      (cnt),
        .peaks    (peaks),
        .indices  (indices),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_peak  (wr_peak),
        .wr_index (wr_index)
    );

endmodule

// File: tb/tb_peak_capture_ctrl.sv
// tb_peak_capture_ctrl
//   Directed bench for peak_capture_ctrl with a small DPRAM model on the
//   write port. Inputs change and outputs are sampled on the falling edge.
module tb_peak_capture_ctrl;

    localparam int CH = 8;
    localparam int NP = 16;
    localparam int VW = 16;
    localparam int IW = 11;
    localparam int AW = 7;
    localparam int N  = CH * NP;

    logic              clk = 1'b0;
    logic              aresetn;
    logic [CH-1:0]     ch_done;
    logic [N*VW-1:0]   peaks;
    logic [N*IW-1:0]   indices;
    logic              host_ack;
    logic              clr_overrun;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [VW-1:0]     wr_peak;
    logic [IW-1:0]     wr_index;
    logic              busy;
    logic              peaks_ready;
    logic              overrun;
    logic [15:0]       frame_cnt;

    int vectors     = 0;
    int miscompares = 0;

    logic [VW-1:0] mem_peak  [N];
    logic [IW-1:0] mem_index [N];
    int unsigned   writes = 0;

    // Free-running stream clock.
    always #5 clk = ~clk;

    peak_capture_ctrl #(
        .CHANNELS    (CH),
        .NUM_PEAKS   (NP),
        .VALUE_WIDTH (VW),
        .INDEX_WIDTH (IW),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk         (clk),
        .aresetn     (aresetn),
        .ch_done     (ch_done),
        .peaks       (peaks),
        .indices     (indices),
        .host_ack    (host_ack),
        .clr_overrun (clr_overrun),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_peak     (wr_peak),
        .wr_index    (wr_index),
        .busy        (busy),
        .peaks_ready (peaks_ready),
        .overrun     (overrun),
        .frame_cnt   (frame_cnt)
    );

    // DPRAM model: captures every write and counts them so each frame's
    // write total can be checked as a difference of snapshots.
    always @(posedge clk) begin
        if (wr_en === 1'b1) begin
            mem_peak[wr_addr]  <= wr_peak;
            mem_index[wr_addr] <= wr_index;
            writes             <= writes + 1;
        end
    end

    // Hard stop in case the directed sequence ever stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then return them to idle at the next
    // falling edge (the rising edge in between has sampled them).
    task automatic applyStimulus(input logic [CH-1:0] done, input logic ack,
                                 input logic clr);
        ch_done     = done;
        host_ack    = ack;
        clr_overrun = clr;
        @(negedge clk);
        ch_done     = '0;
        host_ack    = 1'b0;
        clr_overrun = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitReady(input string tag, input int budget);
        int i = 0;
        while (peaks_ready !== 1'b1 && i < budget) begin
            @(negedge clk);
            i++;
        end
        checkOutput(tag, 32'(peaks_ready), 32'd1);
    endtask

    initial begin
        int bad;
        int unsigned snap;
        int unsigned snap2;

        aresetn     = 1'b0;
        ch_done     = '0;
        host_ack    = 1'b0;
        clr_overrun = 1'b0;
        for (int e = 0; e < N; e++) begin
            peaks[e*VW +: VW]   = VW'(e + 32'h100);
            indices[e*IW +: IW] = IW'(32'h7FF - e);
        end

        // Reset state
        tick(3);
        checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ready", 32'(peaks_ready), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        aresetn = 1'b1;
        tick(2);

        // Test 1: staggered channel completions, full frame stream
        $display("[TB] test 1: staggered ch_done, 128-entry stream");
        snap = writes;
        for (int c = 0; c < CH; c++) applyStimulus(CH'(1) << c, 1'b0, 1'b0);
        checkOutput("t1_collect_busy", 32'(busy), 32'd0);
        tick(1);
        checkOutput("t1_write_busy", 32'(busy), 32'd1);
        checkOutput("t1_no_wr_yet", 32'(wr_en), 32'd0);
        tick(1);
        checkOutput("t1_first_wr_en", 32'(wr_en), 32'd1);
        checkOutput("t1_first_addr", 32'(wr_addr), 32'd0);
        bad = 0;
        for (int i = 1; i < N; i++) begin
            tick(1);
            if (wr_en !== 1'b1 || wr_addr !== AW'(i)) bad++;
        end
        checkOutput("t1_addr_sequence_errors", 32'(bad), 32'd0);
        checkOutput("t1_ready_during_last", 32'(peaks_ready), 32'd0);
        tick(1);
        checkOutput("t1_wr_en_off", 32'(wr_en), 32'd0);
        checkOutput("t1_ready_rise", 32'(peaks_ready), 32'd1);
        checkOutput("t1_write_count", writes - snap, 32'(N));
        tick(3);
        checkOutput("t1_ready_held", 32'(peaks_ready), 32'd1);
        checkOutput("t1_publish_busy", 32'(busy), 32'd1);
        checkOutput("t1_frame_cnt_pre", 32'(frame_cnt), 32'd0);
        applyStimulus('0, 1'b1, 1'b0);
        checkOutput("t1_ready_cleared", 32'(peaks_ready), 32'd0);
        checkOutput("t1_frame_cnt_post", 32'(frame_cnt), 32'd1);
        checkOutput("t1_idle_busy", 32'(busy), 32'd0);
        applyStimulus('0, 1'b1, 1'b0);
        checkOutput("t1_stray_ack_ignored", 32'(frame_cnt), 32'd1);

        // Test 2: DPRAM contents follow the flat bus ordering
        $display("[TB] test 2: DPRAM contents");
        bad = 0;
        for (int a = 0; a < N; a++)
            if (mem_peak[a] !== VW'(a + 32'h100)) bad++;
        checkOutput("t2_peak_contents_errors", 32'(bad), 32'd0);
        bad = 0;
        for (int a = 0; a < N; a++)
            if (mem_index[a] !== IW'(32'h7FF - a)) bad++;
        checkOutput("t2_index_contents_errors", 32'(bad), 32'd0);
        checkOutput("t2_addr5_peak", 32'(mem_peak[5]), 32'h105);
        checkOutput("t2_addr127_index", 32'(mem_index[127]), 32'h780);

        // Test 3: repeated completion on channel 3 sets overrun
        $display("[TB] test 3: overrun");
        snap = writes;
        applyStimulus(8'h08, 1'b0, 1'b0);
        checkOutput("t3_no_overrun_first", 32'(overrun), 32'd0);
        applyStimulus(8'h08, 1'b0, 1'b0);
        checkOutput("t3_overrun_set", 32'(overrun), 32'd1);
        for (int c = 0; c < CH; c++)
            if (c != 3) applyStimulus(CH'(1) << c, 1'b0, 1'b0);
        waitReady("t3_ready_timeout", 300);
        checkOutput("t3_overrun_sticky", 32'(overrun), 32'd1);
        checkOutput("t3_write_count", writes - snap, 32'(N));
        applyStimulus('0, 1'b1, 1'b0);
        checkOutput("t3_frame_cnt", 32'(frame_cnt), 32'd2);
        applyStimulus('0, 1'b0, 1'b1);
        checkOutput("t3_overrun_cleared", 32'(overrun), 32'd0);

        // Test 4: next frame completes during PUBLISH, waits for ack
        $display("[TB] test 4: frame completing during publish");
        applyStimulus(8'hFF, 1'b0, 1'b0);
        waitReady("t4a_ready_timeout", 300);
        applyStimulus(8'hFF, 1'b0, 1'b0);
        snap2 = writes;
        tick(9);
        checkOutput("t4_no_writes_in_publish", writes - snap2, 32'd0);
        checkOutput("t4_ready_still_held", 32'(peaks_ready), 32'd1);
        checkOutput("t4_no_overrun", 32'(overrun), 32'd0);
        applyStimulus('0, 1'b1, 1'b0);
        checkOutput("t4_frame_cnt", 32'(frame_cnt), 32'd3);
        checkOutput("t4_ack_to_collect", 32'(busy), 32'd0);
        tick(1);
        checkOutput("t4_write_after_ack", 32'(busy), 32'd1);
        checkOutput("t4_wr_en_not_yet", 32'(wr_en), 32'd0);
        tick(1);
        checkOutput("t4_first_wr_en", 32'(wr_en), 32'd1);
        checkOutput("t4_first_addr", 32'(wr_addr), 32'd0);
        waitReady("t4b_ready_timeout", 300);
        checkOutput("t4_write_count", writes - snap2, 32'(N));
        applyStimulus('0, 1'b1, 1'b0);
        checkOutput("t4_frame_cnt_2", 32'(frame_cnt), 32'd4);

        // Test 5: ch_done[0] on the clearing cycle carries into next frame
        $display("[TB] test 5: pulse on the clearing cycle");
        applyStimulus(8'hFF, 1'b0, 1'b0);
        applyStimulus(8'h01, 1'b0, 1'b0);
        checkOutput("t5_write_started", 32'(busy), 32'd1);
        checkOutput("t5_no_overrun", 32'(overrun), 32'd0);
        waitReady("t5a_ready_timeout", 300);
        applyStimulus('0, 1'b1, 1'b0);
        checkOutput("t5_frame_cnt", 32'(frame_cnt), 32'd5);
        applyStimulus(8'hFE, 1'b0, 1'b0);
        checkOutput("t5_collect_busy", 32'(busy), 32'd0);
        tick(1);
        checkOutput("t5_lat0_kept_write", 32'(busy), 32'd1);
        tick(1);
        checkOutput("t5_first_wr_en", 32'(wr_en), 32'd1);
        waitReady("t5b_ready_timeout", 300);
        checkOutput("t5_overrun_still_0", 32'(overrun), 32'd0);
        applyStimulus('0, 1'b1, 1'b0);
        checkOutput("t5_frame_cnt_2", 32'(frame_cnt), 32'd6);

        // Test 6: asynchronous reset in the middle of a frame
        $display("[TB] test 6: reset mid-write");
        applyStimulus(8'hFF, 1'b0, 1'b0);
        tick(2);
        checkOutput("t6_started", 32'(wr_en), 32'd1);
        tick(39);
        checkOutput("t6_addr_before_reset", 32'(wr_addr), 32'd39);
        aresetn = 1'b0;
        #1;
        checkOutput("t6_wr_en_abort", 32'(wr_en), 32'd0);
        checkOutput("t6_busy_abort", 32'(busy), 32'd0);
        checkOutput("t6_ready_abort", 32'(peaks_ready), 32'd0);
        @(negedge clk);
        aresetn = 1'b1;
        tick(5);
        checkOutput("t6_ready_after", 32'(peaks_ready), 32'd0);
        checkOutput("t6_idle_after", 32'(busy), 32'd0);
        checkOutput("t6_no_writes_after", 32'(wr_en), 32'd0);
        snap = writes;
        applyStimulus(8'hFF, 1'b0, 1'b0);
        tick(2);
        checkOutput("t6_restart_addr0_en", 32'(wr_en), 32'd1);
        checkOutput("t6_restart_addr0", 32'(wr_addr), 32'd0);
        waitReady("t6_ready_timeout", 300);
        checkOutput("t6_write_count", writes - snap, 32'(N));
        applyStimulus('0, 1'b1, 1'b0);
        checkOutput("t6_ready_released", 32'(peaks_ready), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
